dut_arbiter: RTL and testbench
==============================

Name: dut_arbiter

Overview:
- Shares the single 8-bit registered datapath (slow-clock byte register) between NUM_REQ requesters, using round-robin arbitration with a bounded burst length.
- Drives the datapath input byte and tracks each issued byte through the datapath latency.
- Routes each returned byte back to the requester that issued it.
- Sits in the i_clk domain, directly in front of the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 2, max consecutive grants to one requester while others wait (1..15).
- DP_LATENCY, 1, cycles from o_dp_valid/o_dp_data to the matching byte on i_dp_data (1..4).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  Synchronous, active-low reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_data  in  NUM_REQ*8  per-requester byte; requester k at bits [8k+7:8k].
- o_req_ready  out  NUM_REQ  one-hot grant; combinational from i_req_valid, pointer, burst state and i_stall.
- i_stall  in  1  when 1, no grants are issued.
- o_dp_data  out  8  byte to datapath input.
- o_dp_valid  out  1  o_dp_data carries a granted byte.
- i_dp_data  in  8  datapath output.
- o_rsp_valid  out  NUM_REQ  one-hot, owner of o_rsp_data.
- o_rsp_data  out  8  returned byte.
- o_busy  out  1  any byte in flight (dp stage or tag pipeline).

Behaviour:
- Reset (i_reset=0 at posedge): all outputs 0, pointer=0, last_grant=none, burst_cnt=0, tag pipeline cleared.
  - In-flight bytes are discarded and no response is produced for them.
  - o_req_ready=0 while i_reset=0.
- Handshake:
  - Transfer on requester k when i_req_valid[k] & o_req_ready[k] at a posedge.
  - Requesters must not make valid depend on ready.
  - At most one grant per cycle; zero grants when i_stall=1 or no valid.
- Arbitration:
  - If last_grant=k, i_req_valid[k]=1 and burst_cnt<MAX_BURST, grant k again.
  - Otherwise search starts at last_grant+1 (mod NUM_REQ), or at pointer after reset.
  - First valid in the search wins.
- Burst counter:
  - On a grant to the same k: burst_cnt+1.
  - On a grant to a different requester: burst_cnt=1.
  - On a cycle with no grant: burst_cnt=0, last_grant is kept.
  - With MAX_BURST=1 the scheme is pure round-robin.
- Issue stage:
  - A transfer in cycle t gives o_dp_valid=1 and o_dp_data=granted byte in cycle t+1.
  - Otherwise o_dp_valid=0 and o_dp_data holds its last value.
- Tag pipeline:
  - DP_LATENCY-deep shift register of {valid, requester index}, loaded from the issue stage.
  - Its output qualifies i_dp_data in cycle t+1+DP_LATENCY.
- Response stage:
  - In cycle t+2+DP_LATENCY: o_rsp_valid = onehot(tag), o_rsp_data = captured i_dp_data.
  - Default total latency is 3 cycles from handshake to response.
  - Responses are not back-pressured.
  - Order always equals grant order.
- Stall: i_stall affects grants only. In-flight bytes continue and their responses still appear.
- Back-to-back: one grant per cycle sustained; the pipeline never drops or merges entries.
- o_busy = o_dp_valid | any tag valid | any o_rsp_valid.

Decomposition:
- Package dut_arbiter_pkg holds:
  - DATA_W=8.
  - The MAX_NUM_REQ=8 constant.
  - typedef req_idx_t (3 bits).
  - typedef tag_t struct {logic vld; req_idx_t idx;}.
- Sub-module dut_arb_rr_pick: combinational rotate-priority picker.
  - Inputs: valid vector, start index.
  - Outputs: one-hot grant, index, found flag.
- Top level holds the burst logic, the issue register, the tag shift register and the response register.

Test Plan (NUM_REQ=4, MAX_BURST=2, DP_LATENCY=1, datapath model = 1-cycle register):
- Single request: req 2 valid with 8'hA5 for one cycle → o_req_ready=4'b0100 that cycle; o_dp_valid with 8'hA5 next cycle; o_rsp_valid=4'b0100, o_rsp_data=8'hA5 three cycles after handshake.
- Burst limit: reqs 0 and 1 held valid continuously from reset → grant sequence 0,0,1,1,0,0,1,1; responses return in the same order with the matching data.
- All four valid, MAX_BURST=1 build → grants 0,1,2,3,0 in consecutive cycles; o_rsp_valid walks 1,2,4,8,1 three cycles later.
- Stall: req 3 valid, i_stall=1 for 5 cycles → o_req_ready=0 throughout; a byte issued just before the stall still returns; grant resumes the cycle after i_stall=0.
- Reset mid-flight: grant req 1 with 8'h3C, then i_reset=0 the next cycle → no o_rsp_valid for 8'h3C; all outputs 0; the first grant after reset goes to req 0 if 0 and 1 are both valid.
- Simultaneous: req 0 burst ends (burst_cnt=2) in the same cycle req 3 becomes valid with req 0 still valid → next grant goes to req 1 if valid, else 2, else 3; never req 0.

Source files
------------

// File: rtl/dut_arbiter_pkg.sv
// Shared types and constants for the round-robin datapath arbiter.
// Requester indices are 3 bits wide so up to eight requesters fit.
package dut_arbiter_pkg;

  localparam int DATA_W      = 8;
  localparam int MAX_NUM_REQ = 8;

  typedef logic [2:0] req_idx_t;

  typedef struct packed {
    logic     vld;
    req_idx_t idx;
  } tag_t;

  // Increment an index modulo n (n is the active requester count).
  function automatic req_idx_t wrap_inc(input req_idx_t idx, input int n);
    if (int'(idx) == n - 1) begin
      return '0;
    end
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/dut_arb_rr_pick.sv
// Combinational rotate-priority picker: first valid requester found
// when scanning upward (with wrap) from start_i.
module dut_arb_rr_pick
  import dut_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_idx_t           start_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_idx_t           idx_o,
  output logic               found_o
);

  logic [MAX_NUM_REQ-1:0] valid_ext;

  assign valid_ext = MAX_NUM_REQ'(valid_i);

  always_comb begin
    req_idx_t cand;
    cand    = start_i;
    idx_o   = '0;
    found_o = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found_o && valid_ext[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
      cand = wrap_inc(cand, NUM_REQ);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant_o[gi] = found_o && (idx_o == req_idx_t'(gi));
    end
  endgenerate

endmodule

// File: rtl/dut_arbiter.sv
// Round-robin arbiter with bounded bursts in front of a fixed-latency byte
// datapath; tags every issued byte and routes the returned byte to its owner.
module dut_arbiter
  import dut_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 2,
  parameter int DP_LATENCY = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_stall,
  output logic [DATA_W-1:0]         o_dp_data,
  output logic                      o_dp_valid,
  input  logic [DATA_W-1:0]         i_dp_data,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  logic                   last_vld_q, last_vld_d;
  req_idx_t               last_idx_q, last_idx_d;
  logic [3:0]             burst_cnt_q, burst_cnt_d;
  logic                   dp_valid_q;
  logic [DATA_W-1:0]      dp_data_q;
  req_idx_t               dp_idx_q;
  tag_t                   tag_q [DP_LATENCY];
  tag_t                   tag_out;
  logic                   tag_any;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_data_q;

  logic [MAX_NUM_REQ-1:0] valid_ext;
  logic [DATA_W-1:0]      req_bytes [MAX_NUM_REQ];
  logic [NUM_REQ-1:0]     last_match;
  logic [NUM_REQ-1:0]     pick_grant;
  req_idx_t               pick_idx;
  req_idx_t               start_idx;
  req_idx_t               grant_idx;
  logic                   pick_found;
  logic                   keep_last;
  logic                   grant_en;

  assign valid_ext = MAX_NUM_REQ'(i_req_valid);

  generate
    for (genvar gi = 0; gi < MAX_NUM_REQ; gi++) begin : g_bytes
      if (gi < NUM_REQ) begin : g_used
        assign req_bytes[gi] = i_req_data[gi*DATA_W +: DATA_W];
      end else begin : g_pad
        assign req_bytes[gi] = '0;
      end
    end
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_match
      assign last_match[gi]  = (last_idx_q == req_idx_t'(gi));
      assign rsp_valid_d[gi] = tag_out.vld && (tag_out.idx == req_idx_t'(gi));
    end
  endgenerate

  // Before any grant the scan starts at requester 0.
  assign start_idx = last_vld_q ? wrap_inc(last_idx_q, NUM_REQ) : '0;

  dut_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i (i_req_valid),
    .start_i (start_idx),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign keep_last   = last_vld_q && valid_ext[last_idx_q] && (burst_cnt_q < BURST_LIMIT);
  assign grant_en    = i_reset && !i_stall && (keep_last || pick_found);
  assign grant_idx   = keep_last ? last_idx_q : pick_idx;
  assign o_req_ready = grant_en ? (keep_last ? last_match : pick_grant) : '0;

  always_comb begin
    last_vld_d  = last_vld_q;
    last_idx_d  = last_idx_q;
    burst_cnt_d = '0;
    if (grant_en) begin
      last_vld_d = 1'b1;
      last_idx_d = grant_idx;
      if (last_vld_q && (last_idx_q == grant_idx)) begin
        burst_cnt_d = (burst_cnt_q == 4'hF) ? burst_cnt_q : burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_d = 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      last_vld_q  <= 1'b0;
      last_idx_q  <= '0;
      burst_cnt_q <= '0;
      dp_valid_q  <= 1'b0;
      dp_data_q   <= '0;
      dp_idx_q    <= '0;
    end else begin
      last_vld_q  <= last_vld_d;
      last_idx_q  <= last_idx_d;
      burst_cnt_q <= burst_cnt_d;
      dp_valid_q  <= grant_en;
      if (grant_en) begin
        dp_data_q <= req_bytes[grant_idx];
        dp_idx_q  <= grant_idx;
      end
    end
  end

  // Tag shift register mirrors the datapath latency so the tail tag lines up with i_dp_data.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int s = 0; s < DP_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= {dp_valid_q, dp_idx_q};
      for (int s = 1; s < DP_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign tag_out = tag_q[DP_LATENCY-1];

  always_comb begin
    tag_any = 1'b0;
    for (int s = 0; s < DP_LATENCY; s++) begin
      tag_any = tag_any | tag_q[s].vld;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tag_out.vld) begin
        rsp_data_q <= i_dp_data;
      end
    end
  end

  assign o_dp_valid  = dp_valid_q;
  assign o_dp_data   = dp_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = dp_valid_q | tag_any | (|rsp_valid_q);

endmodule

// File: tb/tb_dut_arbiter.sv
// Directed bench for dut_arbiter: default build plus a MAX_BURST=1 build,
// each fed by a one-cycle register standing in for the datapath.
module tb_dut_arbiter;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  dp_data;
  logic        dp_valid;
  logic [7:0]  dp_q;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  logic [3:0]  rr_valid;
  logic [31:0] rr_data;
  logic [3:0]  rr_ready;
  logic [7:0]  rr_dp_data;
  logic        rr_dp_valid;
  logic [7:0]  rr_dp_q;
  logic [3:0]  rr_rsp_valid;
  logic [7:0]  rr_rsp_data;
  logic        rr_busy;

  int total = 0;
  int bad   = 0;

  dut_arbiter #(.NUM_REQ(4), .MAX_BURST(2), .DP_LATENCY(1)) u_dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_stall     (stall),
    .o_dp_data   (dp_data),
    .o_dp_valid  (dp_valid),
    .i_dp_data   (dp_q),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_busy      (busy)
  );

  dut_arbiter #(.NUM_REQ(4), .MAX_BURST(1), .DP_LATENCY(1)) u_rr (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req_valid (rr_valid),
    .i_req_data  (rr_data),
    .o_req_ready (rr_ready),
    .i_stall     (stall),
    .o_dp_data   (rr_dp_data),
    .o_dp_valid  (rr_dp_valid),
    .i_dp_data   (rr_dp_q),
    .o_rsp_valid (rr_rsp_valid),
    .o_rsp_data  (rr_rsp_data),
    .o_busy      (rr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: a plain byte register.
  always_ff @(posedge clk) begin
    dp_q    <= dp_data;
    rr_dp_q <= rr_dp_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; req_valid = '0; rr_valid = '0; stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    rst_n = 1'b0; req_valid = 4'hF; req_data = 32'h44332211;
    tick();
    #1;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (dp_valid !== 1'b0) begin bad++; $display("FAIL reset_dp_valid got=%b want=0", dp_valid); end
    total++; if (dp_data !== 8'h00) begin bad++; $display("FAIL reset_dp_data got=%h want=00", dp_data); end
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h want=00", rsp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1; req_valid = '0;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_single();
    do_reset();
    tick();
    req_valid = 4'b0100; req_data = 32'h44A52211;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (dp_valid !== 1'b1 || dp_data !== 8'hA5) begin bad++; $display("FAIL single_issue got=%b/%h want=1/a5", dp_valid, dp_data); end
    tick();
    #1;
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL single_early_rsp got=%b want=0000", rsp_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    tick();
    #1;
    total++; if (rsp_valid !== 4'b0100 || rsp_data !== 8'hA5) begin bad++; $display("FAIL single_rsp got=%b/%h want=0100/a5", rsp_valid, rsp_data); end
    tick();
    #1;
    total++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_drain got=%b/%b want=0000/0", rsp_valid, busy); end
    $display("single: req2 byte a5 issued and returned");
  endtask

  task automatic test_burst();
    int unsigned gseq [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    logic [3:0] e;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 8) begin
        req_valid = 4'b0011;
        req_data  = {16'h0000, 8'(i*16 + 1), 8'(i*16)};
      end else begin
        req_valid = '0;
      end
      #1;
      if (i < 8) begin
        e = 4'b0001 << gseq[i];
        total++; if (req_ready !== e) begin bad++; $display("FAIL burst_grant[%0d] got=%b want=%b", i, req_ready, e); end
        $display("burst: cycle %0d grant %b", i, req_ready);
      end
      if (i >= 1 && i <= 8) begin
        d = 8'((i-1)*16 + int'(gseq[i-1]));
        total++; if (dp_valid !== 1'b1 || dp_data !== d) begin bad++; $display("FAIL burst_issue[%0d] got=%b/%h want=1/%h", i, dp_valid, dp_data, d); end
      end
      if (i >= 3 && i <= 10) begin
        e = 4'b0001 << gseq[i-3];
        d = 8'((i-3)*16 + int'(gseq[i-3]));
        total++; if (rsp_valid !== e || rsp_data !== d) begin bad++; $display("FAIL burst_rsp[%0d] got=%b/%h want=%b/%h", i, rsp_valid, rsp_data, e, d); end
      end
    end
  endtask

  task automatic test_rr();
    logic [3:0] e;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 5) begin
        rr_valid = 4'hF;
        rr_data  = {8'(i*16 + 3), 8'(i*16 + 2), 8'(i*16 + 1), 8'(i*16)};
      end else begin
        rr_valid = '0;
      end
      #1;
      if (i < 5) begin
        e = 4'b0001 << (i % 4);
        total++; if (rr_ready !== e) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", i, rr_ready, e); end
        $display("rr: cycle %0d grant %b", i, rr_ready);
      end
      if (i >= 3 && i <= 7) begin
        e = 4'b0001 << ((i-3) % 4);
        d = 8'((i-3)*16 + ((i-3) % 4));
        total++; if (rr_rsp_valid !== e || rr_rsp_data !== d) begin bad++; $display("FAIL rr_rsp[%0d] got=%b/%h want=%b/%h", i, rr_rsp_valid, rr_rsp_data, e, d); end
      end else begin
        total++; if (rr_rsp_valid !== 4'b0) begin bad++; $display("FAIL rr_rsp_idle[%0d] got=%b want=0000", i, rr_rsp_valid); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    req_valid = 4'b1000; req_data = 32'hC3000000; stall = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL stall_pre_grant got=%b want=1000", req_ready); end
    for (int s = 0; s < 5; s++) begin
      tick();
      stall = 1'b1;
      #1;
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0000", s, req_ready); end
      if (s == 0) begin
        total++; if (dp_valid !== 1'b1 || dp_data !== 8'hC3) begin bad++; $display("FAIL stall_issue got=%b/%h want=1/c3", dp_valid, dp_data); end
      end
      if (s == 2) begin
        total++; if (rsp_valid !== 4'b1000 || rsp_data !== 8'hC3) begin bad++; $display("FAIL stall_rsp got=%b/%h want=1000/c3", rsp_valid, rsp_data); end
      end else begin
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL stall_rsp_idle[%0d] got=%b want=0000", s, rsp_valid); end
      end
    end
    tick();
    stall = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL stall_resume got=%b want=1000", req_ready); end
    $display("stall: grant resumed %b", req_ready);
    tick();
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    req_valid = 4'b0010; req_data = 32'h00003C00;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_grant got=%b want=0010", req_ready); end
    tick();
    rst_n = 1'b0; req_valid = 4'b0011;
    #1;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rmid_ready_in_reset got=%b want=0000", req_ready); end
    total++; if (dp_valid !== 1'b1 || dp_data !== 8'h3C) begin bad++; $display("FAIL rmid_issue got=%b/%h want=1/3c", dp_valid, dp_data); end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (dp_valid !== 1'b0 || dp_data !== 8'h00 || rsp_valid !== 4'b0 || rsp_data !== 8'h00 || busy !== 1'b0)
      begin bad++; $display("FAIL rmid_cleared got=%b/%h/%b/%h/%b want=0/00/0000/00/0", dp_valid, dp_data, rsp_valid, rsp_data, busy); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first_grant got=%b want=0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL rmid_no_rsp1 got=%b want=0000", rsp_valid); end
    tick();
    #1;
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL rmid_no_rsp2 got=%b want=0000", rsp_valid); end
    tick();
    #1;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL rmid_new_rsp got=%b want=0001", rsp_valid); end
    $display("reset_mid: discarded 3c, new grant to req0");
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    logic [3:0] vtab [3] = '{4'b1011, 4'b1101, 4'b1001};
    logic [3:0] etab [3] = '{4'b0010, 4'b0100, 4'b1000};
    for (int v = 0; v < 3; v++) begin
      do_reset();
      tick();
      req_valid = 4'b0001; req_data = 32'h44332211;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL sim%0d_first got=%b want=0001", v, req_ready); end
      tick();
      req_valid = 4'b1001;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL sim%0d_second got=%b want=0001", v, req_ready); end
      tick();
      req_valid = vtab[v];
      #1;
      total++; if (req_ready !== etab[v]) begin bad++; $display("FAIL sim%0d_switch got=%b want=%b", v, req_ready, etab[v]); end
      $display("simultaneous: valid %b grant %b", vtab[v], req_ready);
      tick();
      req_valid = '0;
      repeat (4) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    req_valid = '0; req_data = '0;
    rr_valid = '0; rr_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_rr();
    test_stall();
    test_reset_mid();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
